// File: rtl/snn_pkg.sv
// Shared constants, types and edge-weight helpers for the Kronecker SNN array.
// The optional membrane leak is enabled by defining SNN_LEAK_EN.
package snn_pkg;

  localparam int T      = 4;
  localparam int N      = 4;
  localparam int TA     = $clog2(T);
  localparam int NN     = 4;
  localparam int NU     = TA;
  localparam int ALPHA  = 32;
  localparam int THRESH = 16;
  localparam int G      = T * N;
  localparam int GA     = $clog2(G);
  localparam int NA     = $clog2(N);
  localparam int PW     = 8 * NN;
  localparam int WW     = GA + 1;

  typedef logic [PW-1:0] pot_t;
  typedef logic [WW-1:0] wgt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Edge s->d exists when the index bit sets are disjoint; weight is Hamming distance + 1.
  function automatic wgt_t weight(input logic [GA-1:0] s, input logic [GA-1:0] d);
    logic [GA-1:0] x;
    wgt_t          cnt;
    x   = s ^ d;
    cnt = '0;
    for (int i = 0; i < GA; i++) begin
      cnt = cnt + WW'(x[i]);
    end
    if (((s & d) == '0) && (s != d)) begin
      weight = cnt + WW'(1);
    end else begin
      weight = '0;
    end
  endfunction

  function automatic pot_t sat_add(input pot_t a, input wgt_t w);
    logic [PW:0] sum;
    sum = {1'b0, a} + (PW+1)'(w);
    if (sum[PW]) begin
      sat_add = '1;
    end else begin
      sat_add = sum[PW-1:0];
    end
  endfunction

endpackage

// File: rtl/snn_axis_reader.sv
// STREAM-phase AXI-Stream master: walks g = 0..G-1 and emits one potential or fired flag per beat.
module snn_axis_reader
  import snn_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          select,
  input  pot_t          pot [G],
  input  logic [G-1:0]  fired,
  input  logic          tready,
  output logic          tvalid,
  output logic [PW-1:0] tdata,
  output logic [NU-1:0] tuser,
  output logic          tlast,
  output logic          last_hs
);

  logic          arm_r;
  logic [GA-1:0] idx_r;
  logic [GA-1:0] nxt_s;
  logic          tvalid_r;
  logic [PW-1:0] tdata_r;
  logic [NU-1:0] tuser_r;
  logic          tlast_r;
  logic          hs_s;
  pot_t          beat_s;

  assign hs_s    = tvalid_r & tready;
  assign last_hs = hs_s & tlast_r;
  assign tvalid  = tvalid_r;
  assign tdata   = tdata_r;
  assign tuser   = tuser_r;
  assign tlast   = tlast_r;

  // Index and payload of the beat that will be loaded next.
  always_comb begin
    if (arm_r) begin
      nxt_s = '0;
    end else begin
      nxt_s = idx_r + GA'(1);
    end
    if (select) begin
      beat_s = {{(PW-1){1'b0}}, fired[nxt_s]};
    end else begin
      beat_s = pot[nxt_s];
    end
  end

  // Beat register: loads on arm or non-final handshake, holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_r    <= 1'b0;
      idx_r    <= '0;
      tvalid_r <= 1'b0;
      tdata_r  <= '0;
      tuser_r  <= '0;
      tlast_r  <= 1'b0;
    end else begin
      arm_r <= start;
      if (arm_r || (hs_s && !tlast_r)) begin
        tvalid_r <= 1'b1;
        idx_r    <= nxt_s;
        tdata_r  <= beat_s;
        tuser_r  <= NU'(nxt_s / GA'(N));
        tlast_r  <= (nxt_s == GA'(G-1));
      end else if (hs_s) begin
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
        tdata_r  <= '0;
        tuser_r  <= '0;
        idx_r    <= '0;
      end
    end
  end

endmodule

// File: rtl/snn_kron_top.sv
// Kronecker-graph SNN array: spike propagation during time_step, then AXI-Stream readout.
// Define SNN_LEAK_EN to decrement non-fired potentials at every scan-pointer wrap.
module snn_kron_top
  import snn_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          time_step,
  input  logic          force_spike_en,
  input  logic [TA-1:0] force_spike_block_select,
  input  logic [NA-1:0] force_spike_neuron_select,
  input  logic          select,
  output logic          axis_out_tvalid,
  input  logic          axis_out_tready,
  output logic [PW-1:0] axis_out_tdata,
  output logic [NU-1:0] axis_out_tuser,
  output logic          axis_out_tlast,
  output logic          done
);

  state_t        state_r;
  logic          ts_q_r;
  logic [GA-1:0] p_r;
  pot_t          pot_r [G];
  logic [G-1:0]  fired_r;
  logic [G-1:0]  pend_r;
  logic          done_r;
  logic          strm_start_r;

  pot_t          pot_s [G];
  logic [G-1:0]  fired_s;
  logic [G-1:0]  pend_s;
  logic [GA-1:0] g_s;
  wgt_t          w_s;
  logic          wrap_s;
  logic          ts_rise_s;
  logic          ts_fall_s;
  logic          last_hs_s;

  assign ts_rise_s = time_step & ~ts_q_r;
  assign ts_fall_s = ~time_step & ts_q_r;
  assign wrap_s    = (p_r == GA'(G-1));
  assign g_s       = GA'(force_spike_block_select) * GA'(N) + GA'(force_spike_neuron_select);
  assign done      = done_r;

  // Next network state for one RUN cycle: scan hit propagation, threshold firing, injection.
  always_comb begin
    pot_s   = pot_r;
    fired_s = fired_r;
    pend_s  = pend_r;
    w_s     = '0;
    if (state_r == ST_RUN) begin
`ifdef SNN_LEAK_EN
      if (wrap_s) begin
        for (int d = 0; d < G; d++) begin
          if (!fired_r[d] && (pot_r[d] != '0)) begin
            pot_s[d] = pot_r[d] - pot_t'(1);
          end else begin
            pot_s[d] = pot_r[d];
          end
        end
      end else begin
        pot_s = pot_r;
      end
`endif
      if (pend_r[p_r]) begin
        pend_s[p_r] = 1'b0;
        for (int d = 0; d < G; d++) begin
          w_s = weight(p_r, GA'(d));
          if (w_s != '0) begin
            pot_s[d] = sat_add(pot_s[d], w_s);
            if ((pot_s[d] >= pot_t'(THRESH)) && !fired_s[d]) begin
              fired_s[d] = 1'b1;
              pend_s[d]  = 1'b1;
            end else begin
              fired_s[d] = fired_s[d];
            end
          end else begin
            pot_s[d] = pot_s[d];
          end
        end
      end else begin
        pend_s = pend_r;
      end
      // Injection is applied last so it wins over a same-cycle scan clear.
      if (force_spike_en) begin
        pend_s[g_s]  = 1'b1;
        fired_s[g_s] = 1'b1;
      end else begin
        fired_s = fired_s;
      end
    end else begin
      pend_s = pend_r;
    end
  end

  // Phase FSM and neuron state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ts_q_r       <= 1'b0;
      p_r          <= '0;
      fired_r      <= '0;
      pend_r       <= '0;
      done_r       <= 1'b0;
      strm_start_r <= 1'b0;
      for (int i = 0; i < G; i++) begin
        pot_r[i] <= '0;
      end
    end else begin
      ts_q_r       <= time_step;
      strm_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ts_rise_s) begin
            state_r <= ST_RUN;
            fired_r <= '0;
            pend_r  <= '0;
            p_r     <= '0;
            done_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          pot_r   <= pot_s;
          fired_r <= fired_s;
          pend_r  <= pend_s;
          p_r     <= wrap_s ? '0 : p_r + GA'(1);
          if (ts_fall_s) begin
            state_r      <= ST_STREAM;
            strm_start_r <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (last_hs_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  snn_axis_reader u_reader (
    .clk     (clk),
    .reset   (reset),
    .start   (strm_start_r),
    .select  (select),
    .pot     (pot_r),
    .fired   (fired_r),
    .tready  (axis_out_tready),
    .tvalid  (axis_out_tvalid),
    .tdata   (axis_out_tdata),
    .tuser   (axis_out_tuser),
    .tlast   (axis_out_tlast),
    .last_hs (last_hs_s)
  );

endmodule

// File: tb/tb_snn_kron_top.sv
// Randomized self-checking bench for snn_kron_top against a queue-based spike-closure model.
module tb_snn_kron_top;
  import snn_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          time_step = 1'b0;
  logic          force_spike_en = 1'b0;
  logic [TA-1:0] blk = '0;
  logic [NA-1:0] nrn = '0;
  logic          select = 1'b0;
  logic          tready = 1'b0;
  logic          tvalid;
  logic [PW-1:0] tdata;
  logic [NU-1:0] tuser;
  logic          tlast;
  logic          done;

  int checks = 0;
  int failures = 0;
  longint unsigned m_pot [G];
  bit              m_fired [G];

  snn_kron_top dut (
    .clk                       (clk),
    .reset                     (reset),
    .time_step                 (time_step),
    .force_spike_en            (force_spike_en),
    .force_spike_block_select  (blk),
    .force_spike_neuron_select (nrn),
    .select                    (select),
    .axis_out_tvalid           (tvalid),
    .axis_out_tready           (tready),
    .axis_out_tdata            (tdata),
    .axis_out_tuser            (tuser),
    .axis_out_tlast            (tlast),
    .done                      (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_w(input int s, input int d);
    if (((s & d) == 0) && (s != d)) return $countones(s ^ d) + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < G; i++) begin
      m_pot[i] = 0;
      m_fired[i] = 0;
    end
  endtask

  // Fired set is the closure of the injected set under threshold crossing.
  task automatic model_step(input int inj[$]);
    int q[$];
    int s;
    int w;
    for (int i = 0; i < G; i++) m_fired[i] = 0;
    foreach (inj[i]) begin
      m_fired[inj[i]] = 1;
      q.push_back(inj[i]);
    end
    while (q.size() > 0) begin
      s = q.pop_front();
      for (int d = 0; d < G; d++) begin
        w = ref_w(s, d);
        if (w != 0) begin
          m_pot[d] = m_pot[d] + longint'(w);
          if (m_pot[d] > 64'hFFFF_FFFF) m_pot[d] = 64'hFFFF_FFFF;
          if (m_pot[d] >= THRESH && !m_fired[d]) begin
            m_fired[d] = 1;
            q.push_back(d);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    time_step = 1'b0;
    force_spike_en = 1'b0;
    tready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // mode 0: random tready, 1: always ready, 2: ten-cycle stall at beat 5
  task automatic read_stream(input bit sel, input int mode);
    int idx = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit stalled = 0;
    bit seen_last = 0;
    logic [PW-1:0] held_d = '0;
    logic [NU-1:0] held_u = '0;
    logic [63:0] exp_d;
    while (!seen_last && cyc < 400) begin
      if (stalled) begin
        check_val("hold_tdata", tdata, held_d);
        check_val("hold_tuser", tuser, held_u);
      end
      if (mode == 1) tready = 1'b1;
      else if (mode == 2) begin
        if (idx == 5 && stall_cnt < 10) begin
          tready = 1'b0;
          stall_cnt++;
        end else tready = 1'b1;
      end else tready = 1'($urandom_range(0, 1));
      if (!tvalid) begin
        check_val("tvalid_mid", tvalid, 1);
        break;
      end
      if (tready) begin
        exp_d = sel ? 64'(m_fired[idx]) : 64'(m_pot[idx]);
        check_val($sformatf("tdata_g%0d", idx), tdata, exp_d);
        check_val($sformatf("tuser_g%0d", idx), tuser, idx / N);
        check_val($sformatf("tlast_g%0d", idx), tlast, idx == G - 1);
        if (tlast) seen_last = 1;
        idx++;
        stalled = 0;
      end else begin
        stalled = 1;
        held_d = tdata;
        held_u = tuser;
      end
      cyc++;
      @(negedge clk);
    end
    tready = 1'b0;
    check_val("stream_done", seen_last, 1);
    check_val("beat_count", idx, G);
    check_val("tvalid_after", tvalid, 0);
    check_val("done_after", done, 1);
  endtask

  task automatic run_step(input int inj[$], input int hold, input bit sel, input int mode);
    @(negedge clk);
    time_step = 1'b1;
    @(negedge clk);
    check_val("done_clear", done, 0);
    foreach (inj[i]) begin
      force_spike_en = 1'b1;
      blk = TA'(inj[i] / N);
      nrn = NA'(inj[i] % N);
      @(negedge clk);
    end
    force_spike_en = 1'b0;
    repeat (hold) @(negedge clk);
    model_step(inj);
    select = sel;
    time_step = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("lat0_tvalid", tvalid, 0);
    @(negedge clk);
    check_val("lat1_tvalid", tvalid, 0);
    @(negedge clk);
    check_val("lat2_tvalid", tvalid, 1);
    read_stream(sel, mode);
  endtask

  initial begin
    int q[$];
    int a;
    int b;
    int n;

    do_reset();
    check_val("rst_tvalid", tvalid, 0);
    check_val("rst_tlast", tlast, 0);
    check_val("rst_done", done, 0);
    check_val("rst_tdata", tdata, 0);
    check_val("rst_tuser", tuser, 0);

    q = {};
    q.push_back(0);
    run_step(q, 40, 1'b0, 1);

    do_reset();
    q = {};
    q.push_back(15);
    run_step(q, 40, 1'b0, 2);

    do_reset();
    q = {};
    q.push_back(0);
    run_step(q, 40, 1'b0, 0);
    run_step(q, 40, 1'b1, 0);
    q = {};
    run_step(q, 40, 1'b0, 0);

    // Reset in the middle of a stream must drop tvalid without waiting for a clock.
    do_reset();
    q = {};
    q.push_back(0);
    @(negedge clk);
    time_step = 1'b1;
    @(negedge clk);
    force_spike_en = 1'b1;
    blk = '0;
    nrn = '0;
    @(negedge clk);
    force_spike_en = 1'b0;
    repeat (40) @(negedge clk);
    time_step = 1'b0;
    repeat (4) @(negedge clk);
    tready = 1'b1;
    repeat (3) @(negedge clk);
    tready = 1'b0;
    check_val("pre_rst_tvalid", tvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_rst_tvalid", tvalid, 0);
    check_val("async_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    q = {};
    q.push_back(15);
    run_step(q, 40, 1'b0, 0);

    for (int g = 0; g < G; g++) begin
      do_reset();
      q = {};
      q.push_back(g);
      run_step(q, 34, 1'(g % 2), 0);
    end

    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) do_reset();
      q = {};
      n = $urandom_range(0, 2);
      a = $urandom_range(0, G - 1);
      b = (a + 1 + $urandom_range(0, G - 2)) % G;
      if (n >= 1) q.push_back(a);
      if (n >= 2) q.push_back(b);
      run_step(q, 300, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_kron_top.md
Name: snn_kron_top

Overview:
- Small weighted spiking-neural-network array: T blocks × N neurons (G = T*N neurons) connected by a fixed Kronecker-graph weight matrix.
- A time step propagates one externally forced spike; the resulting membrane potentials are then streamed out on an AXI-Stream master.
- Top-level compute block of the SNN project; testbench drives it directly.

Parameters:
- T, 4, number of blocks
- N, 4, neurons per block
- TA, $clog2(T), block-select width
- NN, 4, tdata bytes (32-bit potentials)
- NU, TA, tuser width
- ALPHA, 32, minimum cycles time_step is held high
- THRESH, 16, firing threshold

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- time_step  in  1  high = propagation phase; falling edge starts readout
- force_spike_en  in  1  one-cycle pulse that injects a spike
- force_spike_block_select  in  TA  block of the injected spike
- force_spike_neuron_select  in  $clog2(N)  neuron of the injected spike
- select  in  1  0 = stream potentials; 1 = stream fired flags
- axis_out_tvalid  out  1  stream valid
- axis_out_tready  in  1  stream ready
- axis_out_tdata  out  8*NN  potential (select=0) or {31'b0, fired} (select=1)
- axis_out_tuser  out  NU  block index of the beat
- axis_out_tlast  out  1  final beat
- done  out  1  readout complete

Behaviour:
- Reset: potentials, fired and pending flags cleared; FSM to IDLE; tvalid, tlast and done are 0; tdata and tuser are 0.
- Global index g = block*N + neuron.
- Edge s->d exists iff (s & d) == 0 and s != d; weight = popcount(s ^ d) + 1.
- FSM IDLE -> RUN on time_step rising edge: clear fired/pending flags (potentials persist); deassert done.
- RUN: force_spike_en sets pending[g] and fired[g]. force_spike_en is ignored outside RUN.
- RUN scan: pointer p cycles 0..G-1, wrapping, one index per cycle. If pending[p], clear pending[p] and, in the same cycle, add w(p,d) to every connected d.
- Firing: a neuron whose updated potential is >= THRESH and is not yet fired sets fired and pending. Each neuron fires at most once per step.
- Potential additions saturate at 2^32-1.
- RUN -> STREAM on time_step falling edge.
- STREAM: tvalid rises 2 cycles after the falling edge is sampled. G beats are sent in order g = 0..G-1, with tuser = g / N and tlast on g = G-1.
- Backpressure: beat contents hold while tvalid & !tready; the beat advances on tvalid & tready.
- After the tlast handshake: tvalid = 0, go to IDLE, done = 1 until the next time_step rise.
- Simultaneous injection and scan hit on the same neuron: injection wins (pending stays set).
- time_step edges during STREAM are ignored.
- Reset mid-operation aborts immediately to the reset state.

Optional Feature:
- Macro SNN_LEAK_EN.
- Defined: at each pointer wrap (p = G-1 -> 0) during RUN, every non-fired neuron with nonzero potential decrements by 1.
- Undefined: no leak; potentials change only by weighted accumulation.

Decomposition:
- snn_pkg holds T, N, TA, NN, NU, ALPHA, THRESH, G, the potential type, and the function weight(s, d) that returns the edge weight (0 = no edge).
- One sub-module, snn_axis_reader: STREAM-phase beat counter, tuser/tlast generation and handshake; it reads the potential/fired arrays.

Test Plan:
- Force block 0 / neuron 0 (g=0) -> stream 16 beats: potential[0] = 0; potential[d] = popcount(d)+1 for d > 0 (e.g. d=3 -> 3, d=15 -> 5); tuser 0,0,0,0,1,…,3; tlast only on beat 15.
- Force block 3 / neuron 3 (g=15) after reset -> potential[0] = 5; all others 0.
- Hold tready low 10 cycles mid-stream, then release -> no beat lost or duplicated; tdata/tuser stable while stalled.
- Two steps without reset, forcing g=0 twice -> potential[15] = 10, which is < THRESH, so it does not fire; with select=1, fired = 1 only at g=0.
- Assert reset during STREAM -> tvalid drops asynchronously; next step restarts from zeroed potentials.
- Force every g in sequence, resetting between each (T*N runs) -> each stream has exactly G beats and done = 1 afterwards.
